// File: rtl/dino_pkg.sv
// Shared constants and state types for the dinosaur game pixel source.
package dino_pkg;

    localparam logic [11:0] SKY_COLOR    = 12'hFFF;
    localparam logic [11:0] GROUND_COLOR = 12'h888;
    localparam logic [11:0] DINO_COLOR   = 12'h0F0;
    localparam logic [11:0] OBS_COLOR    = 12'h00F;

    localparam int unsigned DINO_SIZE   = 32;
    localparam int unsigned OBS_W       = 16;
    localparam int unsigned OBS_H       = 32;
    localparam int unsigned GROUND_ROWS = 4;
    localparam int unsigned MAX_COL     = 639;
    localparam int unsigned MAX_ROW     = 479;

    typedef enum logic {
        RUN,
        OVER
    } game_state_t;

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        FALL
    } dino_state_t;

endpackage

// File: rtl/dino_jump_fsm.sv
// Dino jump controller: GROUND/RISE/FALL sequencing and the jump height register.
module dino_jump_fsm
    import dino_pkg::*;
#(
    parameter int unsigned JUMP_H    = 96,
    parameter int unsigned JUMP_STEP = 4
) (
    input  logic       vga_clk,
    input  logic       clr,
    input  logic       frame_tick,
    input  logic       jump,
    input  logic       enable,
    input  logic       restart,
    output logic [6:0] h
);

    dino_state_t state;
    logic [7:0]  h_up;

    assign h_up = {1'b0, h} + 8'(JUMP_STEP);

    // Advance the jump once per frame; restart takes priority over normal motion.
    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            state <= GROUND;
            h     <= '0;
        end else if (frame_tick) begin
            if (restart) begin
                state <= GROUND;
                h     <= '0;
            end else if (enable) begin
                case (state)
                    GROUND: begin
                        if (jump) state <= RISE;
                    end
                    RISE: begin
                        if (h_up >= 8'(JUMP_H)) begin
                            h     <= 7'(JUMP_H);
                            state <= FALL;
                        end else begin
                            h <= h_up[6:0];
                        end
                    end
                    FALL: begin
                        if ({1'b0, h} <= 8'(JUMP_STEP)) begin
                            h     <= '0;
                            state <= GROUND;
                        end else begin
                            h <= h - 7'(JUMP_STEP);
                        end
                    end
                    default: begin
                        state <= GROUND;
                        h     <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/dino_scene.sv
// Dinosaur game pixel source: per-frame game state update and zero-latency rendering.
module dino_scene
    import dino_pkg::*;
#(
    parameter int unsigned DINO_X    = 64,
    parameter int unsigned GROUND_Y  = 400,
    parameter int unsigned JUMP_H    = 96,
    parameter int unsigned JUMP_STEP = 4,
    parameter int unsigned OBS_SPEED = 4
) (
    input  logic        vga_clk,
    input  logic        clr,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    input  logic        jump,
    output logic [11:0] pixel,
    output logic        frame_tick,
    output logic [6:0]  dino_h,
    output logic [9:0]  obs_x,
    output logic        game_over,
    output logic [15:0] score
);

    game_state_t game_st;
    logic        jump_prev;
    logic        collide;
    logic        enable;
    logic        restart;
    logic [11:0] obs_w;
    logic [11:0] h_w;
    logic [11:0] row_w;
    logic [11:0] col_w;
    logic        in_dino;
    logic        in_obs;
    logic        in_ground;

    assign obs_w = 12'(obs_x);
    assign h_w   = 12'(dino_h);
    assign row_w = 12'(row_addr);
    assign col_w = 12'(col_addr);

    // Collision uses the values currently on screen, before this tick's update.
    assign collide = (obs_w < 12'(DINO_X + DINO_SIZE)) &&
                     (obs_w + 12'(OBS_W) > 12'(DINO_X)) &&
                     (h_w < 12'(DINO_SIZE));
    assign enable  = (game_st == RUN) && !collide;
    assign restart = (game_st == OVER) && jump && !jump_prev;

    dino_jump_fsm #(
        .JUMP_H    (JUMP_H),
        .JUMP_STEP (JUMP_STEP)
    ) u_jump (
        .vga_clk    (vga_clk),
        .clr        (clr),
        .frame_tick (frame_tick),
        .jump       (jump),
        .enable     (enable),
        .restart    (restart),
        .h          (dino_h)
    );

    // Pulse once after the last visible pixel of the frame is read.
    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= !rdn && (row_addr == 9'(MAX_ROW)) && (col_addr == 10'(MAX_COL));
        end
    end

    // Game FSM, obstacle motion and score, all updated only on the frame tick.
    always_ff @(posedge vga_clk or posedge clr) begin
        if (clr) begin
            game_st   <= RUN;
            game_over <= 1'b0;
            obs_x     <= 10'(MAX_COL);
            score     <= '0;
            jump_prev <= 1'b0;
        end else if (frame_tick) begin
            jump_prev <= jump;
            case (game_st)
                RUN: begin
                    if (collide) begin
                        game_st   <= OVER;
                        game_over <= 1'b1;
                    end else begin
                        if (obs_x < 10'(OBS_SPEED)) obs_x <= 10'(MAX_COL);
                        else                        obs_x <= obs_x - 10'(OBS_SPEED);
                        if (score != '1) score <= score + 16'd1;
                    end
                end
                OVER: begin
                    if (restart) begin
                        game_st   <= RUN;
                        game_over <= 1'b0;
                        obs_x     <= 10'(MAX_COL);
                        score     <= '0;
                    end
                end
                default: begin
                    game_st   <= RUN;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    // Render with fixed priority: dino, obstacle, ground, sky; blank when not reading.
    always_comb begin
        in_dino   = (col_w >= 12'(DINO_X)) && (col_w < 12'(DINO_X + DINO_SIZE)) &&
                    (row_w + h_w + 12'(DINO_SIZE) >= 12'(GROUND_Y)) &&
                    (row_w + h_w < 12'(GROUND_Y));
        in_obs    = (col_w >= obs_w) && (col_w < obs_w + 12'(OBS_W)) &&
                    (col_w <= 12'(MAX_COL)) &&
                    (row_w + 12'(OBS_H) >= 12'(GROUND_Y)) && (row_w < 12'(GROUND_Y));
        in_ground = (row_w >= 12'(GROUND_Y)) && (row_w < 12'(GROUND_Y + GROUND_ROWS));
        pixel     = SKY_COLOR;
        if (rdn)            pixel = '0;
        else if (in_dino)   pixel = DINO_COLOR;
        else if (in_obs)    pixel = OBS_COLOR;
        else if (in_ground) pixel = GROUND_COLOR;
    end

endmodule

// File: tb/tb_dino_scene.sv
// Self-checking bench for dino_scene: vector table, directed game sequences, random play.
module tb_dino_scene;

    logic        vga_clk = 1'b0;
    logic        clr;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic        jump;
    logic [11:0] pixel;
    logic        frame_tick;
    logic [6:0]  dino_h;
    logic [9:0]  obs_x;
    logic        game_over;
    logic [15:0] score;

    dino_scene #(
        .DINO_X    (64),
        .GROUND_Y  (400),
        .JUMP_H    (96),
        .JUMP_STEP (4),
        .OBS_SPEED (4)
    ) dut (
        .vga_clk    (vga_clk),
        .clr        (clr),
        .row_addr   (row_addr),
        .col_addr   (col_addr),
        .rdn        (rdn),
        .jump       (jump),
        .pixel      (pixel),
        .frame_tick (frame_tick),
        .dino_h     (dino_h),
        .obs_x      (obs_x),
        .game_over  (game_over),
        .score      (score)
    );

    always #20 vga_clk = ~vga_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference game model: the jump is a trajectory indexed by ticks since takeoff.
    int m_obs, m_score, m_since, m_over, m_jprev;

    function automatic int m_h();
        if (m_since <= 0)  return 0;
        if (m_since <= 24) return 4 * m_since;
        return 4 * (48 - m_since);
    endfunction

    function automatic void model_reset();
        m_obs = 639; m_score = 0; m_since = -1; m_over = 0; m_jprev = 0;
    endfunction

    function automatic void model_tick(input logic j);
        if (m_over == 0) begin
            if (m_obs < 96 && m_obs + 16 > 64 && m_h() < 32) begin
                m_over = 1;
            end else begin
                if (m_since < 0) begin
                    if (j) m_since = 0;
                end else begin
                    m_since++;
                    if (m_since == 48) m_since = -1;
                end
                m_obs = (m_obs < 4) ? 639 : m_obs - 4;
                if (m_score < 65535) m_score++;
            end
        end else if (j && m_jprev == 0) begin
            m_over = 0; m_since = -1; m_obs = 639; m_score = 0;
        end
        m_jprev = j ? 1 : 0;
    endfunction

    function automatic logic [11:0] model_pix(input int r, input int c, input logic rd);
        int h;
        h = m_h();
        if (rd) return 12'h000;
        if (c >= 64 && c < 96 && r >= 368 - h && r <= 399 - h) return 12'h0F0;
        if (c >= m_obs && c <= m_obs + 15 && c <= 639 && r >= 368 && r <= 399) return 12'h00F;
        if (r >= 400 && r <= 403) return 12'h888;
        return 12'hFFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_obs_x"},     32'(obs_x),     32'(m_obs));
        check({tag, "_dino_h"},    32'(dino_h),    32'(m_h()));
        check({tag, "_score"},     32'(score),     32'(m_score));
        check({tag, "_game_over"}, 32'(game_over), 32'(m_over));
    endtask

    task automatic probe(input string name, input int r, input int c, input logic rd);
        @(negedge vga_clk);
        row_addr = 9'(r); col_addr = 10'(c); rdn = rd;
        #1;
        check(name, 32'(pixel), 32'(model_pix(r, c, rd)));
        rdn = 1'b1;
    endtask

    task automatic do_tick(input logic j, input string tag);
        @(negedge vga_clk);
        jump = j; row_addr = 9'd479; col_addr = 10'd639; rdn = 1'b0;
        @(negedge vga_clk);
        rdn = 1'b1;
        check({tag, "_tick_hi"}, 32'(frame_tick), 32'd1);
        @(negedge vga_clk);
        check({tag, "_tick_lo"}, 32'(frame_tick), 32'd0);
        model_tick(j);
        check_state(tag);
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        clr = 1'b1; jump = 1'b0; rdn = 1'b1; row_addr = '0; col_addr = '0;
        repeat (2) @(negedge vga_clk);
        clr = 1'b0;
        model_reset();
        @(negedge vga_clk);
    endtask

    typedef struct {
        logic [8:0]  row;
        logic [9:0]  col;
        logic        rd;
        logic [11:0] pix;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_frozen;
        bit hit;
        clr = 1'b0; jump = 1'b0; rdn = 1'b1; row_addr = '0; col_addr = '0;
        do_reset();

        // Reset state.
        check("rst_obs_x", 32'(obs_x), 32'd639);
        check("rst_dino_h", 32'(dino_h), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);

        // Pixel table at reset state: h=0, obstacle at 639.
        vecs[0]  = '{9'd368, 10'd64,  1'b0, 12'h0F0};
        vecs[1]  = '{9'd399, 10'd95,  1'b0, 12'h0F0};
        vecs[2]  = '{9'd367, 10'd64,  1'b0, 12'hFFF};
        vecs[3]  = '{9'd380, 10'd96,  1'b0, 12'hFFF};
        vecs[4]  = '{9'd380, 10'd63,  1'b0, 12'hFFF};
        vecs[5]  = '{9'd380, 10'd639, 1'b0, 12'h00F};
        vecs[6]  = '{9'd368, 10'd639, 1'b0, 12'h00F};
        vecs[7]  = '{9'd380, 10'd638, 1'b0, 12'hFFF};
        vecs[8]  = '{9'd400, 10'd639, 1'b0, 12'h888};
        vecs[9]  = '{9'd400, 10'd10,  1'b0, 12'h888};
        vecs[10] = '{9'd403, 10'd10,  1'b0, 12'h888};
        vecs[11] = '{9'd404, 10'd10,  1'b0, 12'hFFF};
        vecs[12] = '{9'd380, 10'd70,  1'b1, 12'h000};
        vecs[13] = '{9'd479, 10'd0,   1'b0, 12'hFFF};
        for (int i = 0; i < 14; i++) begin
            @(negedge vga_clk);
            row_addr = vecs[i].row; col_addr = vecs[i].col; rdn = vecs[i].rd;
            #1;
            check($sformatf("vec%0d_pixel", i), 32'(pixel), 32'(vecs[i].pix));
        end
        rdn = 1'b1;

        // First frame.
        do_tick(1'b0, "frame1");
        check("frame1_obs_635", 32'(obs_x), 32'd635);
        check("frame1_score_1", 32'(score), 32'd1);
        probe("frame1_sky", 300, 10, 1'b0);
        probe("frame1_ground", 401, 10, 1'b0);

        // Full jump: takeoff tick, 24 rising, 24 falling, then stays on ground.
        do_tick(1'b1, "takeoff");
        check("takeoff_h0", 32'(dino_h), 32'd0);
        for (int i = 0; i < 24; i++) do_tick(1'b0, "rise");
        check("apex_96", 32'(dino_h), 32'd96);
        probe("apex_dino_top", 272, 64, 1'b0);
        probe("apex_above", 271, 64, 1'b0);
        for (int i = 0; i < 24; i++) do_tick(1'b0, "fall");
        check("landed_0", 32'(dino_h), 32'd0);
        do_tick(1'b0, "ground_hold");
        check("ground_hold_0", 32'(dino_h), 32'd0);

        // Jump over the obstacle, then ride it to the wrap.
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            do_tick(m_obs == 151 && m_since < 0, "avoid");
            if (m_obs == 3) begin hit = 1; break; end
        end
        check("wrap_reached", 32'(hit), 32'd1);
        check("prewrap_obs_3", 32'(obs_x), 32'd3);
        check("avoid_no_over", 32'(game_over), 32'd0);
        do_tick(1'b0, "wrap");
        check("wrap_obs_639", 32'(obs_x), 32'd639);
        probe("wrap_obs_pixel", 380, 639, 1'b0);

        // Collision with jump pressed on the collision tick.
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            if (m_obs == 95) begin hit = 1; break; end
            do_tick(1'b0, "approach");
        end
        check("approach_reached", 32'(hit), 32'd1);
        s_frozen = m_score;
        do_tick(1'b1, "collide");
        check("collide_over", 32'(game_over), 32'd1);
        check("collide_obs_95", 32'(obs_x), 32'd95);
        check("collide_h0", 32'(dino_h), 32'd0);
        check("collide_score", 32'(score), 32'(s_frozen));
        for (int i = 0; i < 3; i++) do_tick(1'b1, "held");
        check("held_still_over", 32'(game_over), 32'd1);
        check("held_score", 32'(score), 32'(s_frozen));

        // Rising edge restarts.
        do_tick(1'b0, "release");
        do_tick(1'b1, "restart");
        check("restart_run", 32'(game_over), 32'd0);
        check("restart_score", 32'(score), 32'd0);
        check("restart_obs", 32'(obs_x), 32'd639);

        // Random play with pixel probes.
        for (int i = 0; i < 400; i++) begin
            do_tick($urandom_range(0, 7) == 0, "rand");
            probe("rand_pixel", int'($urandom_range(0, 478)), int'($urandom_range(0, 639)),
                  $urandom_range(0, 3) == 0);
        end

        // Mid-frame asynchronous reset.
        do_tick(1'b0, "pre_rst");
        @(negedge vga_clk);
        row_addr = 9'd200; col_addr = 10'd300; rdn = 1'b0;
        #5 clr = 1'b1;
        #1;
        check("midrst_obs", 32'(obs_x), 32'd639);
        check("midrst_score", 32'(score), 32'd0);
        check("midrst_h", 32'(dino_h), 32'd0);
        check("midrst_over", 32'(game_over), 32'd0);
        @(negedge vga_clk);
        clr = 1'b0; rdn = 1'b1;
        model_reset();
        do_tick(1'b0, "post_rst");
        check("post_rst_obs_635", 32'(obs_x), 32'd635);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
